// File: rtl/pll_dyncfg_ctrl_if.sv
// Control-register side of the PLL dynamic-configuration master.
// Carries profile writes, load requests and sequence status.
// master = SoC register block, slave = pll_dyncfg_ctrl.
interface pll_dyncfg_ctrl_if #(
    parameter int CFG_WIDTH = 27,
    parameter int PW        = 2,
    parameter int RW        = 2
);
    logic                 i_prof_wr_en;
    logic [PW-1:0]        i_prof_wr_idx;
    logic [CFG_WIDTH-1:0] i_prof_wr_data;
    logic                 i_start;
    logic [PW-1:0]        i_start_idx;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;
    logic                 o_locked;
    logic [PW-1:0]        o_active_idx;
    logic [RW-1:0]        o_retry_cnt;

    modport master (
        output i_prof_wr_en, i_prof_wr_idx, i_prof_wr_data, i_start, i_start_idx,
        input  o_busy, o_done, o_error, o_locked, o_active_idx, o_retry_cnt
    );

    modport slave (
        input  i_prof_wr_en, i_prof_wr_idx, i_prof_wr_data, i_start, i_start_idx,
        output o_busy, o_done, o_error, o_locked, o_active_idx, o_retry_cnt
    );
endinterface

// File: rtl/pll_dyncfg_ctrl.sv
// Stores PLL config profiles and serially loads one (SCK/SDI, RESETB low), then waits for stable lock with retries.
// Latency: busy/resetb=0 one cycle after start; first SCK rise SCK_DIV cycles later; all outputs registered.
// Backpressure: start is ignored while busy; profile writes are always accepted (the active word is a private copy).
module pll_dyncfg_ctrl #(
    parameter int                   CFG_WIDTH    = 27,
    parameter int                   NUM_PROFILES = 4,
    parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG  = '0,
    parameter int                   SCK_DIV      = 4,
    parameter int                   RESET_HOLD   = 16,
    parameter int                   LOCK_STABLE  = 4,
    parameter int                   LOCK_TIMEOUT = 65535,
    parameter int                   MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst,
    pll_dyncfg_ctrl_if.slave ctrl,
    input  logic             i_pll_lock,
    output logic             o_pll_sck,
    output logic             o_pll_sdi,
    output logic             o_pll_resetb
);
    localparam int PW   = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BW   = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam int SW   = $clog2(LOCK_STABLE + 1);
    localparam int TM1  = (RESET_HOLD > SCK_DIV) ? RESET_HOLD : SCK_DIV;
    localparam int TMAX = (LOCK_TIMEOUT > TM1) ? LOCK_TIMEOUT : TM1;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ASSERT_RST = 3'd1,
        S_SHIFT      = 3'd2,
        S_HOLD       = 3'd3,
        S_WAIT_LOCK  = 3'd4
    } state_t;

    logic [CFG_WIDTH-1:0] r_prof [NUM_PROFILES];
    logic [1:0]           r_lock_sync;

    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_cnt, w_cnt_nxt;
    logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
    logic [SW-1:0]        r_stable, w_stable_nxt;
    logic [CFG_WIDTH-1:0] r_word, w_word_nxt;
    logic [CFG_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                 r_sck, w_sck_nxt;
    logic                 r_sdi, w_sdi_nxt;
    logic                 r_resetb, w_resetb_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_error, w_error_nxt;
    logic                 r_success, w_success_nxt;
    logic                 r_locked, w_locked_nxt;
    logic [PW-1:0]        r_active_idx, w_idx_nxt;
    logic [RW-1:0]        r_retry, w_retry_nxt;

    logic                 w_wr_ok;
    logic                 w_start_ok;
    logic                 w_lock;

    // Both index checks are done one bit wider so the compare never truncates NUM_PROFILES.
    assign w_wr_ok    = ({1'b0, ctrl.i_prof_wr_idx} < (PW+1)'(NUM_PROFILES));
    assign w_start_ok = ({1'b0, ctrl.i_start_idx}   < (PW+1)'(NUM_PROFILES));
    assign w_lock     = r_lock_sync[1];

    // Profile storage; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                r_prof[i] <= (i == 0) ? DEFAULT_CFG : '0;
            end
        end else if (ctrl.i_prof_wr_en && w_wr_ok) begin
            r_prof[ctrl.i_prof_wr_idx] <= ctrl.i_prof_wr_data;
        end
    end

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (rst) r_lock_sync <= 2'b00;
        else     r_lock_sync <= {r_lock_sync[0], i_pll_lock};
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_stable     <= '0;
            r_word       <= '0;
            r_shift      <= '0;
            r_sck        <= 1'b0;
            r_sdi        <= 1'b0;
            r_resetb     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_success    <= 1'b0;
            r_locked     <= 1'b0;
            r_active_idx <= '0;
            r_retry      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_stable     <= w_stable_nxt;
            r_word       <= w_word_nxt;
            r_shift      <= w_shift_nxt;
            r_sck        <= w_sck_nxt;
            r_sdi        <= w_sdi_nxt;
            r_resetb     <= w_resetb_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_success    <= w_success_nxt;
            r_locked     <= w_locked_nxt;
            r_active_idx <= w_idx_nxt;
            r_retry      <= w_retry_nxt;
        end
    end

    // Next-state and next-output logic; SDI changes only on the SCK falling edge (or before the first rise).
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + TW'(1);
        w_bit_nxt     = r_bit_cnt;
        w_stable_nxt  = r_stable;
        w_word_nxt    = r_word;
        w_shift_nxt   = r_shift;
        w_sck_nxt     = r_sck;
        w_sdi_nxt     = r_sdi;
        w_resetb_nxt  = r_resetb;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_error_nxt   = r_error;
        w_success_nxt = r_success;
        w_idx_nxt     = r_active_idx;
        w_retry_nxt   = r_retry;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (ctrl.i_start) begin
                    if (w_start_ok) begin
                        w_state_nxt   = S_ASSERT_RST;
                        w_word_nxt    = r_prof[ctrl.i_start_idx];
                        w_shift_nxt   = r_prof[ctrl.i_start_idx];
                        w_sdi_nxt     = r_prof[ctrl.i_start_idx][CFG_WIDTH-1];
                        w_sck_nxt     = 1'b0;
                        w_bit_nxt     = '0;
                        w_resetb_nxt  = 1'b0;
                        w_busy_nxt    = 1'b1;
                        w_error_nxt   = 1'b0;
                        w_success_nxt = 1'b0;
                        w_retry_nxt   = '0;
                        w_idx_nxt     = ctrl.i_start_idx;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            S_ASSERT_RST: begin
                if (r_cnt == TW'(SCK_DIV - 1)) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_sck_nxt   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == TW'(SCK_DIV - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_sck) begin
                        w_sck_nxt = 1'b0;
                        if (r_bit_cnt == BW'(CFG_WIDTH - 1)) begin
                            w_state_nxt = S_HOLD;
                            w_sdi_nxt   = 1'b0;
                        end else begin
                            w_bit_nxt   = r_bit_cnt + BW'(1);
                            w_shift_nxt = r_shift << 1;
                            w_sdi_nxt   = r_shift[CFG_WIDTH-2];
                        end
                    end else begin
                        w_sck_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == TW'(RESET_HOLD - 1)) begin
                    w_state_nxt  = S_WAIT_LOCK;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                    w_resetb_nxt = 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                w_stable_nxt = w_lock ? (r_stable + SW'(1)) : '0;
                if (w_lock && (r_stable == SW'(LOCK_STABLE - 1))) begin
                    w_state_nxt   = S_IDLE;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_success_nxt = 1'b1;
                end else if (r_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                    w_resetb_nxt = 1'b0;
                    if (r_retry < RW'(MAX_RETRY)) begin
                        // Reload from the private copy so profile writes made meanwhile do not leak in.
                        w_state_nxt = S_ASSERT_RST;
                        w_retry_nxt = r_retry + RW'(1);
                        w_shift_nxt = r_word;
                        w_sdi_nxt   = r_word[CFG_WIDTH-1];
                        w_bit_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_error_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_locked_nxt = (w_state_nxt == S_IDLE) && w_success_nxt && w_lock;
    end

    assign o_pll_sck         = r_sck;
    assign o_pll_sdi         = r_sdi;
    assign o_pll_resetb      = r_resetb;
    assign ctrl.o_busy       = r_busy;
    assign ctrl.o_done       = r_done;
    assign ctrl.o_error      = r_error;
    assign ctrl.o_locked     = r_locked;
    assign ctrl.o_active_idx = r_active_idx;
    assign ctrl.o_retry_cnt  = r_retry;
endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// Directed bench for pll_dyncfg_ctrl: serial load framing, lock handshake, retries, aborts.
// Three profiles are configured so that index 3 is an out-of-range request on a 2-bit index.
// Inputs change #1 after the rising edge; outputs are read at that same point.
module tb_pll_dyncfg_ctrl;
    localparam logic [26:0] DEF_CFG = 27'h6C3A5E1;
    localparam logic [26:0] W1      = 27'h5A3C0F1;
    localparam logic [26:0] W2      = 27'h2B4D1E7;
    localparam logic [26:0] W2B     = 27'h7FFFFFF;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic pll_sck, pll_sdi, pll_resetb;

    pll_dyncfg_ctrl_if #(.CFG_WIDTH(27), .PW(2), .RW(2)) ifc ();

    pll_dyncfg_ctrl #(
        .CFG_WIDTH(27), .NUM_PROFILES(3), .DEFAULT_CFG(DEF_CFG), .SCK_DIV(2),
        .RESET_HOLD(16), .LOCK_STABLE(4), .LOCK_TIMEOUT(50), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .ctrl(ifc), .i_pll_lock(pll_lock),
        .o_pll_sck(pll_sck), .o_pll_sdi(pll_sdi), .o_pll_resetb(pll_resetb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation results
    int          rises, first_rise, last_fall, rb_rise, dones, viol_total;
    logic [26:0] cap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Runs up to limit cycles recording SCK/RESETB events (k = cycles since call).
    // mode 0: stop at RESETB rise; 1: stop when busy low; 2: stop at stop_n-th rise; 3: run full limit.
    // At k == inj_k a start to profile 1 and a write to profile 2 are pulsed for one cycle.
    task automatic observe(input int limit, input int mode, input int stop_n, input int inj_k);
        logic ps, pr;
        rises = 0; first_rise = -1; last_fall = -1; rb_rise = -1; dones = 0; cap = '0;
        ps = pll_sck; pr = pll_resetb;
        for (int k = 1; k <= limit; k++) begin
            if (k == inj_k) begin
                ifc.i_start = 1'b1; ifc.i_start_idx = 2'd1;
                ifc.i_prof_wr_en = 1'b1; ifc.i_prof_wr_idx = 2'd2; ifc.i_prof_wr_data = W2B;
            end
            tick(1);
            ifc.i_start = 1'b0; ifc.i_prof_wr_en = 1'b0;
            if (pll_sck && !ps) begin
                rises++;
                cap = {cap[25:0], pll_sdi};
                if (first_rise < 0) first_rise = k;
            end
            if (!pll_sck && ps) last_fall = k;
            if ((pll_sck !== ps) && pll_resetb) viol_total++;
            if (pll_resetb && !pr) rb_rise = k;
            if (ifc.o_done) dones++;
            ps = pll_sck; pr = pll_resetb;
            if (mode == 0 && rb_rise > 0) break;
            if (mode == 1 && !ifc.o_busy) break;
            if (mode == 2 && rises == stop_n) break;
        end
    endtask

    task automatic start_load(input logic [1:0] idx);
        ifc.i_start = 1'b1; ifc.i_start_idx = idx;
        tick(1);
        ifc.i_start = 1'b0;
    endtask

    task automatic wr_prof(input logic [1:0] idx, input logic [26:0] d);
        ifc.i_prof_wr_en = 1'b1; ifc.i_prof_wr_idx = idx; ifc.i_prof_wr_data = d;
        tick(1);
        ifc.i_prof_wr_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sck"},    64'(pll_sck), 64'd0);
        chk({tag, "_sdi"},    64'(pll_sdi), 64'd0);
        chk({tag, "_resetb"}, 64'(pll_resetb), 64'd0);
        chk({tag, "_busy"},   64'(ifc.o_busy), 64'd0);
        chk({tag, "_done"},   64'(ifc.o_done), 64'd0);
        chk({tag, "_error"},  64'(ifc.o_error), 64'd0);
        chk({tag, "_locked"}, 64'(ifc.o_locked), 64'd0);
        chk({tag, "_aidx"},   64'(ifc.o_active_idx), 64'd0);
        chk({tag, "_retry"},  64'(ifc.o_retry_cnt), 64'd0);
    endtask

    initial begin
        int n;
        viol_total = 0;
        rst = 1'b1; pll_lock = 1'b0;
        ifc.i_prof_wr_en = 1'b0; ifc.i_prof_wr_idx = '0; ifc.i_prof_wr_data = '0;
        ifc.i_start = 1'b0; ifc.i_start_idx = '0;
        tick(2);
        chk_reset_state("rst");
        rst = 1'b0;
        tick(1);

        // Load profile 1: 27 rises of W1, rise 2 cycles after busy, 4-cycle period, 16-cycle hold.
        wr_prof(2'd1, W1);
        wr_prof(2'd2, W2);
        start_load(2'd1);
        chk("t1_busy", 64'(ifc.o_busy), 64'd1);
        chk("t1_resetb_low", 64'(pll_resetb), 64'd0);
        chk("t1_aidx", 64'(ifc.o_active_idx), 64'd1);
        observe(400, 0, 0, 0);
        chk("t1_rises", 64'(rises), 64'd27);
        chk("t1_word", 64'(cap), 64'(W1));
        chk("t1_first_rise", 64'(first_rise), 64'd2);
        chk("t1_shift_span", 64'(last_fall - first_rise), 64'd106);
        chk("t1_hold", 64'(rb_rise - last_fall), 64'd16);

        // Lock 30 cycles after release: done after 2 sync + 4 stable cycles.
        tick(30);
        pll_lock = 1'b1;
        n = 0;
        while (!ifc.o_done && n < 20) begin tick(1); n++; end
        chk("t2_done_latency", 64'(n), 64'd6);
        chk("t2_busy_with_done", 64'(ifc.o_busy), 64'd0);
        chk("t2_locked", 64'(ifc.o_locked), 64'd1);
        chk("t2_error", 64'(ifc.o_error), 64'd0);
        chk("t2_retry", 64'(ifc.o_retry_cnt), 64'd0);
        observe(5, 3, 0, 0);
        chk("t2_done_once", 64'(dones), 64'd0);
        chk("t2_locked_hold", 64'(ifc.o_locked), 64'd1);
        pll_lock = 1'b0;
        tick(3);
        chk("t2_lock_loss", 64'(ifc.o_locked), 64'd0);
        observe(20, 3, 0, 0);
        chk("t2_no_reload_rises", 64'(rises), 64'd0);
        chk("t2_no_reload_resetb", 64'(pll_resetb), 64'd1);
        chk("t2_no_reload_busy", 64'(ifc.o_busy), 64'd0);

        // 3-cycle lock glitch is rejected; a later sustained lock completes.
        start_load(2'd2);
        observe(400, 0, 0, 0);
        chk("t3_word", 64'(cap), 64'(W2));
        tick(5);
        pll_lock = 1'b1;
        tick(3);
        pll_lock = 1'b0;
        observe(10, 3, 0, 0);
        chk("t3_glitch_no_done", 64'(dones), 64'd0);
        chk("t3_glitch_busy", 64'(ifc.o_busy), 64'd1);
        pll_lock = 1'b1;
        n = 0;
        while (!ifc.o_done && n < 20) begin tick(1); n++; end
        chk("t3_done_latency", 64'(n), 64'd6);
        pll_lock = 1'b0;
        tick(3);

        // Out-of-range index in IDLE: error, no PLL activity, active index kept.
        start_load(2'd3);
        chk("t5_bad_idx_error", 64'(ifc.o_error), 64'd1);
        chk("t5_bad_idx_busy", 64'(ifc.o_busy), 64'd0);
        observe(20, 3, 0, 0);
        chk("t5_bad_idx_rises", 64'(rises), 64'd0);
        chk("t5_bad_idx_resetb", 64'(pll_resetb), 64'd1);
        chk("t5_bad_idx_aidx", 64'(ifc.o_active_idx), 64'd2);

        // Start + profile write during SHIFT are ignored for the running load; then no lock -> 4 loads.
        start_load(2'd2);
        chk("t4_error_cleared", 64'(ifc.o_error), 64'd0);
        observe(400, 0, 0, 20);
        chk("t4_rises", 64'(rises), 64'd27);
        chk("t4_word", 64'(cap), 64'(W2));
        chk("t4_aidx", 64'(ifc.o_active_idx), 64'd2);
        chk("t4_rb_rise", 64'(rb_rise), 64'd124);
        observe(1500, 1, 0, 0);
        chk("t4_retry_rises", 64'(rises), 64'd81);
        chk("t4_retry_word", 64'(cap), 64'(W2));
        chk("t4_timeout_error", 64'(ifc.o_error), 64'd1);
        chk("t4_timeout_retry", 64'(ifc.o_retry_cnt), 64'd3);
        chk("t4_timeout_resetb", 64'(pll_resetb), 64'd0);
        chk("t4_timeout_busy", 64'(ifc.o_busy), 64'd0);
        chk("t4_timeout_dones", 64'(dones), 64'd0);

        // Reset at the 10th SCK rise aborts; afterwards profile 0 loads its reset value.
        start_load(2'd0);
        chk("t6_error_cleared", 64'(ifc.o_error), 64'd0);
        observe(200, 2, 10, 0);
        chk("t6_reached_rise10", 64'(rises), 64'd10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset_state("t6_abort");
        observe(30, 3, 0, 0);
        chk("t6_quiet_rises", 64'(rises), 64'd0);
        start_load(2'd0);
        observe(400, 0, 0, 0);
        chk("t6_reload_rises", 64'(rises), 64'd27);
        chk("t6_reload_word", 64'(cap), 64'(DEF_CFG));

        chk("sck_while_released", 64'(viol_total), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
